// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT stage types, constants and helper functions
package fft_pkg;

  // Per-bank lifecycle of a ping-pong frame store
  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_WRITING = 2'd1,
    ST_FULL    = 2'd2,
    ST_READING = 2'd3
  } stage_state_t;

  // Widest index the bit-reversal helper can handle (frames up to 64k samples)
  localparam int BR_MAX = 16;

  // Ceiling log2, used for elaboration-time address widths
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Reverse the low log_n bits of value; bits above log_n come back as zero.
  // Built as a shift chain so no variable bit index is needed.
  function automatic logic [BR_MAX-1:0] bitreverse(input logic [BR_MAX-1:0] value,
                                                   input int log_n);
    logic [BR_MAX-1:0] src;
    logic [BR_MAX-1:0] res;
    src = value;
    res = '0;
    for (int i = 0; i < BR_MAX; i++) begin
      if (i < log_n) begin
        res = {res[BR_MAX-2:0], src[0]};
        src = src >> 1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stage_ram.sv
// rtl/stage_ram.sv - simple dual-port frame RAM with a registered read port
module stage_ram
  import fft_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int DW    = 33,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  // Write port; storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read port register; reset so the replay output starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/stage_pingpong.sv
// rtl/stage_pingpong.sv - two-bank ping-pong frame store with natural or bit-reversed replay
module stage_pingpong
  import fft_pkg::*;
#(
  parameter int N      = 16,
  parameter int LOG_N  = 4,
  parameter int WIDTH  = 32,
  parameter int MWIDTH = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [MWIDTH-1:0] in_m,
  input  logic              in_nd,
  input  logic              bitrev,
  input  logic              read_en,
  output logic [WIDTH-1:0]  out_data,
  output logic [MWIDTH-1:0] out_m,
  output logic              out_nd,
  output logic              out_first,
  output logic [3:0]        bank_state,
  output logic              error
);

  localparam int              DW       = WIDTH + MWIDTH;
  localparam logic [LOG_N-1:0] LAST_IDX = LOG_N'(N - 1);

  stage_state_t bank_st     [2];
  stage_state_t bank_st_nxt [2];

  logic             wbank;
  logic             rbank;
  logic [LOG_N-1:0] waddr;
  logic [LOG_N-1:0] raddr;
  logic             rd_bitrev;
  logic             err_q;
  logic             out_nd_q;
  logic             out_first_q;

  logic             wr_ok;
  logic             wr_last;
  logic             overflow;
  logic             rd_start;
  logic             issue;
  logic             rd_last;
  logic [LOG_N-1:0] rd_idx;
  logic [DW-1:0]    ram_q;

  // Bank state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st[0] <= ST_EMPTY;
      bank_st[1] <= ST_EMPTY;
    end else begin
      bank_st[0] <= bank_st_nxt[0];
      bank_st[1] <= bank_st_nxt[1];
    end
  end

  // Bank transitions: writer and reader never own the same bank, so their updates never collide
  always_comb begin
    bank_st_nxt[0] = bank_st[0];
    bank_st_nxt[1] = bank_st[1];
    if (wr_ok)    bank_st_nxt[wbank] = wr_last ? ST_FULL : ST_WRITING;
    if (rd_start) bank_st_nxt[rbank] = ST_READING;
    if (rd_last)  bank_st_nxt[rbank] = ST_EMPTY;
  end

  // Write acceptance, read issue and replay address decode
  always_comb begin
    wr_ok    = in_nd && ((bank_st[wbank] == ST_EMPTY) || (bank_st[wbank] == ST_WRITING));
    overflow = in_nd && !wr_ok;
    wr_last  = wr_ok && (waddr == LAST_IDX);
    rd_start = read_en && (bank_st[rbank] == ST_FULL);
    issue    = rd_start || (read_en && (bank_st[rbank] == ST_READING));
    rd_last  = issue && (raddr == LAST_IDX);
    // On the starting issue raddr is 0, which reverses to 0, so a stale rd_bitrev is harmless
    rd_idx   = rd_bitrev ? LOG_N'(bitreverse(BR_MAX'(raddr), LOG_N)) : raddr;
  end

  // Write/read pointers, per-frame order latch and sticky overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank     <= 1'b0;
      waddr     <= '0;
      rbank     <= 1'b0;
      raddr     <= '0;
      rd_bitrev <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (wr_ok) begin
        waddr <= wr_last ? '0 : waddr + 1'b1;
        if (wr_last) wbank <= ~wbank;
      end
      if (issue) begin
        if (rd_last) begin
          raddr <= '0;
          rbank <= ~rbank;
        end else begin
          raddr <= raddr + 1'b1;
        end
      end
      if (rd_start) rd_bitrev <= bitrev;
      if (overflow) err_q     <= 1'b1;
    end
  end

  // Output strobes track the one-cycle RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_nd_q    <= 1'b0;
      out_first_q <= 1'b0;
    end else begin
      out_nd_q    <= issue;
      out_first_q <= rd_start;
    end
  end

  stage_ram #(
    .DEPTH (2 * N),
    .DW    (DW)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_ok),
    .wr_addr ({wbank, waddr}),
    .wr_data ({in_data, in_m}),
    .rd_en   (issue),
    .rd_addr ({rbank, rd_idx}),
    .rd_data (ram_q)
  );

  assign out_data   = ram_q[DW-1:MWIDTH];
  assign out_m      = ram_q[MWIDTH-1:0];
  assign out_nd     = out_nd_q;
  assign out_first  = out_first_q;
  assign bank_state = {bank_st[1], bank_st[0]};
  assign error      = err_q;

endmodule

// File: tb/tb_stage_pingpong.sv
// tb/tb_stage_pingpong.sv - directed scoreboard bench for stage_pingpong
module tb_stage_pingpong;

  localparam int N      = 8;
  localparam int LOG_N  = 3;
  localparam int WIDTH  = 32;
  localparam int MWIDTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [WIDTH-1:0]  in_data;
  logic [MWIDTH-1:0] in_m;
  logic              in_nd;
  logic              bitrev;
  logic              read_en;
  logic [WIDTH-1:0]  out_data;
  logic [MWIDTH-1:0] out_m;
  logic              out_nd;
  logic              out_first;
  logic [3:0]        bank_state;
  logic              error;

  typedef struct packed {
    logic [WIDTH-1:0]  d;
    logic [MWIDTH-1:0] m;
    logic              first;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   n_out, n_first, first_out_cyc, last_out_cyc;

  stage_pingpong #(
    .N      (N),
    .LOG_N  (LOG_N),
    .WIDTH  (WIDTH),
    .MWIDTH (MWIDTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_m       (in_m),
    .in_nd      (in_nd),
    .bitrev     (bitrev),
    .read_en    (read_en),
    .out_data   (out_data),
    .out_m      (out_m),
    .out_nd     (out_nd),
    .out_first  (out_first),
    .bank_state (bank_state),
    .error      (error)
  );

  always #5 clk = ~clk;

  function automatic logic [MWIDTH-1:0] meta_of(input logic [WIDTH-1:0] d);
    return d[3:0] ^ d[11:8] ^ 4'h9;
  endfunction

  function automatic int rev3(input int i);
    return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor(input logic ren_prev);
    exp_t e;
    if (out_nd === 1'b1) begin
      n_out++;
      if (n_out == 1) first_out_cyc = cyc;
      last_out_cyc = cyc;
      if (out_first === 1'b1) n_first++;
      chk("out_nd_needs_read_en", {63'd0, ren_prev}, 64'd1);
      chk("out_expected", {63'd0, sb.size() > 0}, 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_data", {32'd0, out_data}, {32'd0, e.d});
        chk("out_m", {60'd0, out_m}, {60'd0, e.m});
        chk("out_first", {63'd0, out_first}, {63'd0, e.first});
      end
    end else begin
      chk("out_first_idle", {63'd0, out_first}, 64'd0);
    end
  endtask

  task automatic step();
    logic ren;
    ren = read_en;
    @(posedge clk);
    #1;
    cyc++;
    monitor(ren);
  endtask

  task automatic put(input logic [WIDTH-1:0] d);
    in_nd   = 1'b1;
    in_data = d;
    in_m    = meta_of(d);
    step();
    in_nd   = 1'b0;
  endtask

  task automatic write_frame(input logic [WIDTH-1:0] base);
    for (int k = 0; k < N; k++) put(base + WIDTH'(k));
  endtask

  task automatic push_frame(input logic [WIDTH-1:0] base, input logic rev);
    exp_t e;
    int   idx;
    for (int k = 0; k < N; k++) begin
      idx     = rev ? rev3(k) : k;
      e.d     = base + WIDTH'(idx);
      e.m     = meta_of(e.d);
      e.first = (k == 0);
      sb.push_back(e);
    end
  endtask

  task automatic drain(input int budget, input logic toggle);
    for (int i = 0; i < budget && sb.size() > 0; i++) begin
      if (toggle) read_en = ~read_en;
      step();
    end
    chk("drain_complete", 64'(sb.size()), 64'd0);
    step();
    step();
  endtask

  task automatic clear_stats();
    n_out = 0;
    n_first = 0;
    first_out_cyc = 0;
    last_out_cyc = 0;
  endtask

  initial begin
    rst_n   = 1'b0;
    in_data = '0;
    in_m    = '0;
    in_nd   = 1'b0;
    bitrev  = 1'b0;
    read_en = 1'b0;
    clear_stats();
    step();
    step();

    // reset state
    chk("rst_out_nd", {63'd0, out_nd}, 64'd0);
    chk("rst_out_first", {63'd0, out_first}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_m", {60'd0, out_m}, 64'd0);
    chk("rst_bank_state", {60'd0, bank_state}, 64'd0);
    chk("rst_error", {63'd0, error}, 64'd0);
    rst_n = 1'b1;
    step();
    chk("idle_bank_state", {60'd0, bank_state}, 64'd0);

    // natural order frame, latency from last write
    clear_stats();
    read_en = 1'b1;
    write_frame(32'h100);
    push_frame(32'h100, 1'b0);
    chk("nat_full_state", {60'd0, bank_state}, 64'h2);
    chk("nat_no_early_out", {63'd0, out_nd}, 64'd0);
    step();
    chk("nat_first_latency", {63'd0, out_nd}, 64'd1);
    chk("nat_first_flag", {63'd0, out_first}, 64'd1);
    chk("nat_reading_state", {60'd0, bank_state}, 64'h3);
    drain(40, 1'b0);
    chk("nat_count", 64'(n_out), 64'd8);
    chk("nat_first_count", 64'(n_first), 64'd1);
    chk("nat_released", {60'd0, bank_state}, 64'd0);

    // bit-reversed frame, bitrev dropped mid-frame, then a natural frame
    clear_stats();
    bitrev = 1'b1;
    write_frame(32'h200);
    push_frame(32'h200, 1'b1);
    step();
    bitrev = 1'b0;
    drain(40, 1'b0);
    chk("rev_count", 64'(n_out), 64'd8);
    clear_stats();
    write_frame(32'h300);
    push_frame(32'h300, 1'b0);
    drain(40, 1'b0);
    chk("rev_next_natural_count", 64'(n_out), 64'd8);

    // continuous stream of four frames
    clear_stats();
    for (int k = 0; k < 4 * N; k++) begin
      put(32'h400 + WIDTH'(k));
      if (k % N == N - 1) push_frame(32'h400 + WIDTH'(k - (N - 1)), 1'b0);
    end
    drain(40, 1'b0);
    chk("cont_count", 64'(n_out), 64'd32);
    chk("cont_no_gaps", 64'(last_out_cyc - first_out_cyc + 1), 64'd32);
    chk("cont_error", {63'd0, error}, 64'd0);

    // read_en alternating every cycle
    clear_stats();
    for (int k = 0; k < 2 * N; k++) begin
      read_en = (k % 2 == 0);
      put(32'h500 + WIDTH'(k));
      if (k % N == N - 1) push_frame(32'h500 + WIDTH'(k - (N - 1)), 1'b0);
    end
    drain(80, 1'b1);
    chk("toggle_count", 64'(n_out), 64'd16);
    chk("toggle_first_count", 64'(n_first), 64'd2);
    chk("toggle_span", 64'(last_out_cyc - first_out_cyc + 1), 64'd31);
    chk("toggle_error", {63'd0, error}, 64'd0);

    // overflow with the reader stalled
    clear_stats();
    read_en = 1'b0;
    for (int k = 0; k < 3 * N; k++) begin
      put(32'h600 + WIDTH'(k));
      if (k == 15) begin
        chk("ovf_both_full", {60'd0, bank_state}, 64'hA);
        chk("ovf_error_before", {63'd0, error}, 64'd0);
      end
      if (k == 16) chk("ovf_error_set", {63'd0, error}, 64'd1);
    end
    chk("ovf_no_output", 64'(n_out), 64'd0);
    push_frame(32'h600, 1'b0);
    push_frame(32'h608, 1'b0);
    read_en = 1'b1;
    drain(60, 1'b0);
    chk("ovf_count", 64'(n_out), 64'd16);
    chk("ovf_error_sticky", {63'd0, error}, 64'd1);

    // reset in the middle of a replay
    clear_stats();
    write_frame(32'h700);
    push_frame(32'h700, 1'b0);
    step();
    step();
    chk("pre_reset_outputs", 64'(n_out), 64'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_nd", {63'd0, out_nd}, 64'd0);
    chk("mid_rst_out_first", {63'd0, out_first}, 64'd0);
    chk("mid_rst_out_data", {32'd0, out_data}, 64'd0);
    chk("mid_rst_bank_state", {60'd0, bank_state}, 64'd0);
    chk("mid_rst_error", {63'd0, error}, 64'd0);
    sb.delete();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk("post_rst_no_output", 64'(n_out), 64'd2);
    chk("post_rst_bank_state", {60'd0, bank_state}, 64'd0);
    clear_stats();
    write_frame(32'h800);
    push_frame(32'h800, 1'b0);
    drain(40, 1'b0);
    chk("post_rst_count", 64'(n_out), 64'd8);
    chk("post_rst_error", {63'd0, error}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stage_pingpong.md
# stage_pingpong

Double-buffered (ping-pong) frame store for the FFT pipeline: accepts a stream of N-sample frames with per-sample metadata and replays each completed frame in natural or bit-reversed order while the next frame is being written. It supersedes the single-bank fill-then-empty stage harness: two banks give overlapped write and read, read pacing is controlled by `read_en`, and output order is selectable per frame. It sits between the input buffer and the butterfly stages, or at the FFT output for reordering.

## Interface
- `N`, 16: frame length; power of two, at least 4.
- `LOG_N`, 4: log2(N); must equal clog2(N).
- `WIDTH`, 32: sample data width.
- `MWIDTH`, 1: per-sample metadata width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `in_data`  in  WIDTH  sample to store
- `in_m`  in  MWIDTH  metadata stored alongside the sample
- `in_nd`  in  1  in_data/in_m valid this cycle
- `bitrev`  in  1  1 = read the next frame in bit-reversed order; sampled when a bank enters READING
- `read_en`  in  1  permit one read issue this cycle
- `out_data`  out  WIDTH  replayed sample
- `out_m`  out  MWIDTH  replayed metadata
- `out_nd`  out  1  out_data/out_m valid
- `out_first`  out  1  with out_nd, marks the first sample of a frame
- `bank_state`  out  4  {bank1, bank0} state, 2 bits each
- `error`  out  1  sticky overflow flag

## Operation
- Bank states: EMPTY=0, WRITING=1, FULL=2, READING=3.
- Write pointer `wbank` and index `waddr`:
  - An `in_nd` targeting a bank that is EMPTY or WRITING stores {in_data, in_m} at {wbank, waddr}.
  - That write moves the bank to WRITING (from EMPTY) and increments `waddr`.
  - On the write with `waddr`=N-1, the bank becomes FULL, `waddr` wraps to 0 and `wbank` toggles.
- Overflow: `in_nd` while the target bank is FULL or READING drops the sample, sets `error`, and leaves all pointers and states unchanged.
- Read pointer `rbank` and index `raddr`:
  - When bank `rbank` is FULL and `read_en`=1, that cycle issues a read at index 0, the bank becomes READING, and `bitrev` is latched for the frame.
  - Each subsequent cycle with `read_en`=1 issues the next index.
  - Issued RAM address is {rbank, raddr} in natural order, or {rbank, bitreverse(raddr)} when the latched `bitrev` is 1.
  - `read_en`=0 stalls issue; nothing is lost.
- Frame completion: on issue of `raddr`=N-1, the bank becomes EMPTY at the next edge and `rbank` toggles.
  - If the other bank is already FULL and `read_en`=1 the following cycle, its frame starts with no gap cycle.
- Release/write collision: the EMPTY release takes effect on the next edge. A write arriving in the same cycle as the final read of its target bank counts as an overflow.
- Reader/writer interaction: the reader never reads a bank that is EMPTY or WRITING; the writer never writes a bank that is FULL or READING.
- `error` stays set until reset.

## Timing
- RAM read latency is 1 cycle: an issue in cycle t gives `out_nd`=1 with data in cycle t+1.
- `out_first` is asserted in the cycle after the index-0 issue.
- Write-to-readable latency:
  - Last write at edge t makes the bank FULL after t.
  - The earliest issue is cycle t+1; the earliest `out_nd` is cycle t+2.
- Sustained throughput is 1 sample/cycle in and out with both banks alternating.
- Reset values: all banks EMPTY, `wbank`=`rbank`=0, `waddr`=`raddr`=0, latched bitrev 0, `out_nd`=0, `out_first`=0, `out_data`=0, `out_m`=0, `error`=0, `bank_state`=0.
- Reset mid-frame discards both banks' contents immediately, with no partial output afterwards. RAM contents are not cleared.
- `bank_state` is registered and reflects the state after the most recent edge.

## Structure
- Shared package `fft_pkg`:
  - stage state constants (EMPTY/WRITING/FULL/READING)
  - `clog2` function
  - `bitreverse` function parametrised by LOG_N
- Sub-module `stage_ram`: simple dual-port RAM, 2N entries of WIDTH+MWIDTH, one write port and one registered read port, addressed by {bank, index}.
- Control (pointers, bank state machines, error) stays in `stage_pingpong`.

## Test plan
- N=8; write samples 0..7 with read_en=1 → out 0..7 in order, out_first with 0, first out_nd 2 cycles after the last write.
- N=8, bitrev=1; write 0..7 → out 0,4,2,6,1,5,3,7; bitrev toggled mid-frame has no effect until the next frame.
- Continuous input 0..31 with read_en=1 → continuous output 0..31, no gap cycles, error=0.
- read_en=0 while writing 0..23 → both banks FULL after sample 15; samples 16..23 dropped, error=1; then read_en=1 → 0..15 out.
- read_en toggling 1,0,1,0 → output gaps match stalls, order intact, out_first once per frame.
- Assert rst_n low for 1 cycle during the read of frame 1 → out_nd=0 at once, bank_state=0, error=0; the next written frame replays correctly.
